compressed_fetch_aligner: RTL and testbench

COMPRESSED_FETCH_ALIGNER -- requirements
Module: compressed_fetch_aligner

---
 rtl/compressed_fetch_aligner.sv | 173 +++++++++++++++++
 tb/tb_compressed_fetch_aligner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/compressed_fetch_aligner.sv
// Realigns a 32-bit word fetch stream into 16/32-bit instructions via a 4-parcel FIFO.
// Define FETCH_BYPASS_EN to forward a fetch response straight to the decoder when the FIFO is empty.
module compressed_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    output logic        FetchReq,
    output logic [29:0] FetchAddr,
    input  logic        FetchAck,
    input  logic [31:0] FetchData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic        InstrCompressed,
    output logic [31:0] InstrPc
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]  state;
    logic [15:0] fifoMem [4];
    logic [1:0]  rdPtr;
    logic [1:0]  wrPtr;
    logic [2:0]  count;
    logic        skipHalf;

    logic        ackAccept;
    logic        transfer;
    logic [15:0] respLo;
    logic [15:0] respHi;
    logic [1:0]  respCount;
    logic [1:0]  respUsed;
    logic [1:0]  pushCount;
    logic [1:0]  popCount;
    logic [15:0] pushFirst;
    logic [15:0] headParcel;
    logic [15:0] nextParcel;
    logic        headCompressed;
    logic        fifoValid;
    logic        bypassValid;
    logic [31:0] bypassInstr;
    logic        unusedPcLsb;

    assign unusedPcLsb = RedirectPc[0];

    assign FetchReq = (state == WAIT);

    // A response is only consumed in WAIT; a redirect in the same cycle throws it away.
    assign ackAccept = (state == WAIT) && FetchAck && !Redirect;
    assign respLo    = skipHalf ? FetchData[31:16] : FetchData[15:0];
    assign respHi    = FetchData[31:16];
    assign respCount = skipHalf ? 2'd1 : 2'd2;

    assign headParcel     = fifoMem[rdPtr];
    assign nextParcel     = fifoMem[rdPtr + 2'd1];
    assign headCompressed = (headParcel[1:0] != 2'b11);
    assign fifoValid      = (count != 3'd0) && (headCompressed || (count >= 3'd2));

`ifdef FETCH_BYPASS_EN
    logic respLoCompressed;

    assign respLoCompressed = (respLo[1:0] != 2'b11);
    // A lone upper half of a 32-bit instruction cannot be forwarded and goes into the FIFO.
    assign bypassValid = ackAccept && (count == 3'd0) && (respLoCompressed || !skipHalf);
    assign bypassInstr = respLoCompressed ? {16'h0000, respLo} : {respHi, respLo};
`else
    assign bypassValid = 1'b0;
    assign bypassInstr = 32'h0000_0000;
`endif

    always_comb begin
        InstrValid      = 1'b0;
        InstrOut        = 32'h0000_0000;
        InstrCompressed = 1'b0;
        if (bypassValid) begin
            InstrValid      = 1'b1;
            InstrOut        = bypassInstr;
            InstrCompressed = (bypassInstr[1:0] != 2'b11);
        end else if (fifoValid) begin
            InstrValid      = 1'b1;
            InstrCompressed = headCompressed;
            InstrOut        = headCompressed ? {16'h0000, headParcel} : {nextParcel, headParcel};
        end
    end

    assign transfer = InstrValid && InstrReady && !Redirect;

    always_comb begin
        popCount  = 2'd0;
        respUsed  = 2'd0;
        pushCount = 2'd0;
        if (transfer) begin
            if (bypassValid) begin
                respUsed = InstrCompressed ? 2'd1 : 2'd2;
            end else begin
                popCount = InstrCompressed ? 2'd1 : 2'd2;
            end
        end
        if (ackAccept) begin
            pushCount = respCount - respUsed;
        end
    end

    // Parcels not taken by the bypass path are stored in arrival order.
    assign pushFirst = (respUsed == 2'd0) ? respLo : respHi;

    always_ff @(posedge Clock) begin
        if (pushCount != 2'd0) begin
            fifoMem[wrPtr] <= pushFirst;
        end
        if (pushCount == 2'd2) begin
            fifoMem[wrPtr + 2'd1] <= respHi;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            count     <= 3'd0;
            rdPtr     <= 2'd0;
            wrPtr     <= 2'd0;
            FetchAddr <= RESET_PC[31:2];
            InstrPc   <= RESET_PC;
            skipHalf  <= RESET_PC[1];
        end else if (Redirect) begin
            count     <= 3'd0;
            rdPtr     <= 2'd0;
            wrPtr     <= 2'd0;
            FetchAddr <= RedirectPc[31:2];
            InstrPc   <= {RedirectPc[31:1], 1'b0};
            skipHalf  <= RedirectPc[1];
            // An outstanding request must still be answered before a new one is issued.
            case (state)
                WAIT:    state <= FetchAck ? IDLE : DISCARD;
                DISCARD: state <= FetchAck ? IDLE : DISCARD;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count <= 3'd2) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (FetchAck) begin
                        state     <= IDLE;
                        FetchAddr <= FetchAddr + 30'd1;
                        skipHalf  <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (FetchAck) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            count <= count + {1'b0, pushCount} - {1'b0, popCount};
            rdPtr <= rdPtr + popCount;
            wrPtr <= wrPtr + pushCount;
            if (transfer) begin
                InstrPc <= InstrPc + (InstrCompressed ? 32'd2 : 32'd4);
            end
        end
    end

endmodule

// File: tb/tb_compressed_fetch_aligner.sv
// Scoreboard bench: a program memory model walks the instruction stream from each redirect target.
module tb_compressed_fetch_aligner;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic        FetchReq;
    logic [29:0] FetchAddr;
    logic        FetchAck;
    logic [31:0] FetchData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] InstrOut;
    logic        InstrCompressed;
    logic [31:0] InstrPc;

    compressed_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .Clock(Clock), .ResetN(ResetN), .Redirect(Redirect), .RedirectPc(RedirectPc),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchAck(FetchAck), .FetchData(FetchData),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrOut(InstrOut),
        .InstrCompressed(InstrCompressed), .InstrPc(InstrPc)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        comp;
        logic [31:0] pc;
        logic [31:0] instr;
    } expT;

    expT         expQ[$];
    logic [31:0] mem [logic [29:0]];
    int          vectors = 0;
    int          miscompares = 0;
    int          transfers = 0;
    int          sinceRedir = 0;
    bit          outstanding = 1'b0;
    logic [29:0] reqAddr;
    int          ackDelay = 0;
    bit          monHeld = 1'b0;
    logic [64:0] monSnap;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] getWord(input logic [29:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [15:0] parcelAt(input logic [31:0] pc);
        logic [31:0] w;
        w = getWord(pc[31:2]);
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected stream: walk the program from pc, 16-bit parcels unless low bits are 2'b11.
    function automatic void startSegment(input logic [31:0] pc);
        logic [31:0] p;
        logic [15:0] h;
        expT         e;
        p = {pc[31:1], 1'b0};
        expQ.delete();
        for (int i = 0; i < 400; i++) begin
            h = parcelAt(p);
            e.pc = p;
            if (h[1:0] != 2'b11) begin
                e.comp  = 1'b1;
                e.instr = {16'h0000, h};
                p = p + 32'd2;
            end else begin
                e.comp  = 1'b0;
                e.instr = {parcelAt(p + 32'd2), h};
                p = p + 32'd4;
            end
            expQ.push_back(e);
        end
    endfunction

    // redirMode: 0 random, 1 none, 2 forced, 3 when waiting without ack, 4 with ack and transfer
    task automatic stepCycle(input int redirMode, input logic [31:0] tgt, input int rdyMode,
                             output bit did);
        bit doIt;
        @(posedge Clock);
        #1;
        FetchAck  = 1'b0;
        FetchData = $urandom;
        if (!outstanding && FetchReq) begin
            outstanding = 1'b1;
            reqAddr     = FetchAddr;
            ackDelay    = $urandom_range(0, 3);
        end
        if (outstanding) begin
            if (ackDelay == 0) begin
                FetchAck    = 1'b1;
                FetchData   = getWord(reqAddr);
                outstanding = 1'b0;
            end else begin
                ackDelay--;
            end
        end
        InstrReady = (rdyMode == 0) ? ($urandom_range(0, 3) != 0) : (rdyMode == 2);
        case (redirMode)
            0: doIt = (sinceRedir >= 150) || ($urandom_range(0, 63) == 0);
            2: doIt = 1'b1;
            3: doIt = FetchReq && !FetchAck;
            4: doIt = FetchReq && FetchAck && InstrValid && InstrReady;
            default: doIt = 1'b0;
        endcase
        if (redirMode == 0) tgt = $urandom & 32'h0000_FFFF;
        Redirect = doIt;
        did = doIt;
        sinceRedir++;
        if (doIt) begin
            RedirectPc = tgt;
            sinceRedir = 0;
            startSegment(tgt);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted instruction, checks stall stability.
    initial begin
        expT e;
        forever begin
            @(negedge Clock);
            if (!ResetN) begin
                monHeld = 1'b0;
            end else begin
                if (monHeld) check("holdStable", {InstrValid, InstrCompressed, InstrPc, InstrOut},
                                   {1'b1, monSnap});
                if (InstrValid && InstrReady && !Redirect) begin
                    transfers++;
                    if (expQ.size() == 0) begin
                        check("unexpectedInstr", {InstrCompressed, InstrPc, InstrOut}, 65'h0);
                    end else begin
                        e = expQ.pop_front();
                        check("instr", {InstrCompressed, InstrPc, InstrOut}, {e.comp, e.pc, e.instr});
                    end
                end
                monHeld = InstrValid && !InstrReady && !Redirect;
                monSnap = {InstrCompressed, InstrPc, InstrOut};
            end
        end
    end

    initial begin
        bit          did;
        logic [65:0] snap;
        ResetN = 1'b0; Redirect = 1'b0; RedirectPc = 32'h0; FetchAck = 1'b0;
        FetchData = 32'h0; InstrReady = 1'b0;
        mem[30'h00] = 32'h0001_4501;
        mem[30'h40] = 32'h0001_0113;
        mem[30'h41] = 32'h0000_4501;
        mem[30'h80] = 32'h0113_4501;
        mem[30'h81] = 32'h0000_0001;
        startSegment(32'h0000_0000);
        repeat (3) @(negedge Clock);
        check("rstFetchReq", FetchReq, 0);
        check("rstInstrValid", InstrValid, 0);
        check("rstInstrOut", InstrOut, 0);
        check("rstInstrCompressed", InstrCompressed, 0);
        check("rstInstrPc", InstrPc, 32'h0);
        check("rstFetchAddr", FetchAddr, 30'h0);
        ResetN = 1'b1;

        stepCycle(1, 32'h0, 0, did);
        check("firstFetchReq", FetchReq, 1);
        check("firstFetchAddr", FetchAddr, 30'h0);
        repeat (30) stepCycle(1, 32'h0, 0, did);

        stepCycle(2, 32'h0000_0100, 0, did);
        repeat (30) stepCycle(1, 32'h0, 0, did);
        stepCycle(2, 32'h0000_0200, 0, did);
        repeat (30) stepCycle(1, 32'h0, 0, did);

        did = 1'b0;
        for (int i = 0; i < 60 && !did; i++) stepCycle(3, 32'h0000_0102, 0, did);
        check("redirectInWait", did, 1);
        stepCycle(1, 32'h0, 0, did);
        check("discardFetchReq", FetchReq, 0);
        check("discardFetchAddr", FetchAddr, 30'h40);
        repeat (30) stepCycle(1, 32'h0, 0, did);

        stepCycle(2, 32'h0000_0300, 1, did);
        repeat (20) stepCycle(1, 32'h0, 1, did);
        snap = {FetchReq, InstrValid, InstrCompressed, InstrPc, InstrOut};
        check("stallValid", InstrValid, 1);
        repeat (10) begin
            stepCycle(1, 32'h0, 1, did);
            check("stallFetchReq", FetchReq, 0);
            check("stallOutputs", {FetchReq, InstrValid, InstrCompressed, InstrPc, InstrOut}, snap);
        end

        did = 1'b0;
        for (int i = 0; i < 300 && !did; i++) stepCycle(4, 32'h0000_0400, 0, did);
        check("redirectAckTransfer", did, 1);
        stepCycle(1, 32'h0, 0, did);
        check("flushInstrValid", InstrValid, 0);
        check("flushFetchReq", FetchReq, 0);

        repeat (3000) stepCycle(0, 32'h0, 0, did);
        Redirect = 1'b0;
        repeat (2) @(posedge Clock);
        check("transfersSeen", transfers > 500, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
